// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared constants, register map and state encoding for the VGA fill engine
package vga_pkg;

  localparam int H_RES = 640;
  localparam int V_RES = 480;

  localparam logic [2:0] REG_CTRL   = 3'd0;
  localparam logic [2:0] REG_STATUS = 3'd1;
  localparam logic [2:0] REG_ORIGIN = 3'd2;
  localparam logic [2:0] REG_SIZE   = 3'd3;
  localparam logic [2:0] REG_COLOR  = 3'd4;

  localparam int CTRL_START   = 0;
  localparam int CTRL_WAIT_VB = 1;
  localparam int CTRL_IRQ_EN  = 2;

  localparam int STAT_BUSY = 0;
  localparam int STAT_DONE = 1;
  localparam int STAT_ERR  = 2;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT_VB = 2'd1,
    FILL    = 2'd2,
    DONE    = 2'd3
  } fill_state_e;

endpackage

// File: rtl/vga_fill_regs.sv
// rtl/vga_fill_regs.sv - APB register slave for the fill engine: decode, config, sticky status
module vga_fill_regs
  import vga_pkg::*;
#(
  parameter int DW = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   i_paddr,
  input  logic          i_psel,
  input  logic          i_penable,
  input  logic          i_pwrite,
  input  logic [31:0]   i_pwdata,
  output logic [31:0]   o_prdata,
  output logic          o_pslverr,
  input  logic          i_busy,
  input  logic          i_set_done,
  input  logic          i_set_err,
  output logic          o_start,
  output logic          o_start_wait_vb,
  output logic          o_irq,
  output logic [9:0]    o_x,
  output logic [9:0]    o_y,
  output logic [9:0]    o_w,
  output logic [9:0]    o_h,
  output logic [DW-1:0] o_color
);

  logic          r_wait_vb;
  logic          r_irq_en;
  logic          r_done;
  logic          r_err;
  logic [9:0]    r_x;
  logic [9:0]    r_y;
  logic [9:0]    r_w;
  logic [9:0]    r_h;
  logic [DW-1:0] r_color;

  logic       w_access;
  logic       w_wr;
  logic       w_rd;
  logic [2:0] w_idx;
  logic       w_bad_idx;
  logic       w_cfg_wr;
  logic       w_start_req;
  logic       w_clr_done;
  logic       w_clr_err;
  logic       w_unused_ok;

  assign w_access    = i_psel & i_penable;
  assign w_idx       = i_paddr[4:2];
  assign w_bad_idx   = (w_idx > REG_COLOR);
  assign w_wr        = w_access & i_pwrite;
  assign w_rd        = w_access & ~i_pwrite;
  assign w_cfg_wr    = w_wr & ((w_idx == REG_ORIGIN) | (w_idx == REG_SIZE) | (w_idx == REG_COLOR));
  assign w_start_req = w_wr & (w_idx == REG_CTRL) & i_pwdata[CTRL_START];
  assign w_clr_done  = w_wr & (w_idx == REG_STATUS) & i_pwdata[STAT_DONE];
  assign w_clr_err   = w_wr & (w_idx == REG_STATUS) & i_pwdata[STAT_ERR];
  assign w_unused_ok = ^{i_paddr[31:5], i_paddr[1:0], i_pwdata};

  // The wait-for-vblank choice travels with the START write itself
  assign o_start         = w_start_req & ~i_busy;
  assign o_start_wait_vb = i_pwdata[CTRL_WAIT_VB];
  assign o_irq           = r_done & r_irq_en;
  assign o_pslverr       = w_access & w_bad_idx;
  assign o_x             = r_x;
  assign o_y             = r_y;
  assign o_w             = r_w;
  assign o_h             = r_h;
  assign o_color         = r_color;

  // Register file; geometry/colour are frozen while busy and sticky sets beat clears
  always_ff @(posedge clock) begin
    if (reset) begin
      r_wait_vb <= 1'b0;
      r_irq_en  <= 1'b0;
      r_done    <= 1'b0;
      r_err     <= 1'b0;
      r_x       <= '0;
      r_y       <= '0;
      r_w       <= '0;
      r_h       <= '0;
      r_color   <= '0;
    end else begin
      if (w_wr && w_idx == REG_CTRL) begin
        r_wait_vb <= i_pwdata[CTRL_WAIT_VB];
        r_irq_en  <= i_pwdata[CTRL_IRQ_EN];
      end
      if (w_wr && !i_busy && w_idx == REG_ORIGIN) begin
        r_x <= i_pwdata[9:0];
        r_y <= i_pwdata[25:16];
      end
      if (w_wr && !i_busy && w_idx == REG_SIZE) begin
        r_w <= i_pwdata[9:0];
        r_h <= i_pwdata[25:16];
      end
      if (w_wr && !i_busy && w_idx == REG_COLOR) begin
        r_color <= i_pwdata[DW-1:0];
      end
      r_done <= i_set_done | (r_done & ~w_clr_done);
      r_err  <= i_set_err | (w_cfg_wr & i_busy) | (w_start_req & i_busy) | (r_err & ~w_clr_err);
    end
  end

  // Read mux: only drives data during a read access to a mapped register
  always_comb begin
    o_prdata = '0;
    if (w_rd && !w_bad_idx) begin
      case (w_idx)
        REG_CTRL:   o_prdata = {29'd0, r_irq_en, r_wait_vb, 1'b0};
        REG_STATUS: o_prdata = {29'd0, r_err, r_done, i_busy};
        REG_ORIGIN: o_prdata = {6'd0, r_y, 6'd0, r_x};
        REG_SIZE:   o_prdata = {6'd0, r_h, 6'd0, r_w};
        REG_COLOR:  o_prdata = {{(32-DW){1'b0}}, r_color};
        default:    o_prdata = '0;
      endcase
    end
  end

endmodule

// File: rtl/vga_fb_fill_ctrl.sv
// rtl/vga_fb_fill_ctrl.sv - rectangle fill engine sharing the framebuffer write port with the CPU
module vga_fb_fill_ctrl #(
  parameter int H_RES = 640,
  parameter int V_RES = 480,
  parameter int AW    = 19,
  parameter int DW    = 24
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [31:0]   paddr,
  input  logic          psel,
  input  logic          penable,
  input  logic          pwrite,
  input  logic [31:0]   pwdata,
  output logic          pready,
  output logic [31:0]   prdata,
  output logic          pslverr,
  input  logic          vblank_start,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          fb_we,
  output logic [AW-1:0] fb_addr,
  output logic [DW-1:0] fb_wdata,
  output logic          irq
);
  import vga_pkg::*;

  localparam logic [10:0] LP_H = 11'(H_RES);
  localparam logic [10:0] LP_V = 11'(V_RES);

  fill_state_e   r_state;
  logic [9:0]    r_cx;
  logic [9:0]    r_row;
  logic [9:0]    r_ew;
  logic [9:0]    r_eh;
  logic [AW-1:0] r_row_base;

  logic          w_start;
  logic          w_start_wait_vb;
  logic [9:0]    w_x;
  logic [9:0]    w_y;
  logic [9:0]    w_w;
  logic [9:0]    w_h;
  logic [DW-1:0] w_color;
  logic          w_busy;
  logic          w_invalid;
  logic [10:0]   w_hrem;
  logic [10:0]   w_vrem;
  logic [9:0]    w_ew;
  logic [9:0]    w_eh;
  logic [AW-1:0] w_y_base;
  logic [AW-1:0] w_eng_addr;
  logic          w_eng_we;

  assign pready = 1'b1;
  assign w_busy = (r_state != IDLE);

  vga_fill_regs #(.DW(DW)) u_regs (
    .clock           (clock),
    .reset           (reset),
    .i_paddr         (paddr),
    .i_psel          (psel),
    .i_penable       (penable),
    .i_pwrite        (pwrite),
    .i_pwdata        (pwdata),
    .o_prdata        (prdata),
    .o_pslverr       (pslverr),
    .i_busy          (w_busy),
    .i_set_done      (r_state == DONE),
    .i_set_err       (w_start & w_invalid),
    .o_start         (w_start),
    .o_start_wait_vb (w_start_wait_vb),
    .o_irq           (irq),
    .o_x             (w_x),
    .o_y             (w_y),
    .o_w             (w_w),
    .o_h             (w_h),
    .o_color         (w_color)
  );

  // Clip the rectangle to the visible area; a valid origin leaves at least one pixel
  assign w_hrem    = LP_H - {1'b0, w_x};
  assign w_vrem    = LP_V - {1'b0, w_y};
  assign w_invalid = (w_w == 10'd0) | (w_h == 10'd0) | ({1'b0, w_x} >= LP_H) | ({1'b0, w_y} >= LP_V);
  assign w_ew      = ({1'b0, w_w} < w_hrem) ? w_w : w_hrem[9:0];
  assign w_eh      = ({1'b0, w_h} < w_vrem) ? w_h : w_vrem[9:0];

  // y*640 as (y<<9)+(y<<7) keeps the row base off a multiplier
  assign w_y_base   = (AW'(w_y) << 9) + (AW'(w_y) << 7);
  assign w_eng_addr = r_row_base + AW'(w_x) + AW'(r_cx);

  // Engine is silenced in the reset cycle itself so an abort never leaks a pixel
  assign w_eng_we = (r_state == FILL) & ~reset;

  // Fill sequencer: validate on START, optional vblank wait, raster walk that stalls on CPU writes
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cx       <= '0;
      r_row      <= '0;
      r_ew       <= '0;
      r_eh       <= '0;
      r_row_base <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_start) begin
            if (w_invalid) begin
              r_state <= DONE;
            end else begin
              r_ew       <= w_ew;
              r_eh       <= w_eh;
              r_cx       <= '0;
              r_row      <= '0;
              r_row_base <= w_y_base;
              r_state    <= w_start_wait_vb ? WAIT_VB : FILL;
            end
          end
        end
        WAIT_VB: begin
          if (vblank_start) r_state <= FILL;
        end
        FILL: begin
          if (!cpu_we) begin
            if (r_cx == r_ew - 10'd1) begin
              if (r_row == r_eh - 10'd1) begin
                r_state <= DONE;
              end else begin
                r_cx       <= '0;
                r_row      <= r_row + 10'd1;
                r_row_base <= r_row_base + AW'(H_RES);
              end
            end else begin
              r_cx <= r_cx + 10'd1;
            end
          end
        end
        DONE: r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Write-port arbiter: the CPU always wins and passes through even during reset
  always_comb begin
    fb_we    = 1'b0;
    fb_addr  = '0;
    fb_wdata = '0;
    if (cpu_we) begin
      fb_we    = 1'b1;
      fb_addr  = cpu_addr;
      fb_wdata = cpu_wdata;
    end else if (w_eng_we) begin
      fb_we    = 1'b1;
      fb_addr  = w_eng_addr;
      fb_wdata = w_color;
    end
  end

endmodule

// File: tb/tb_vga_fb_fill_ctrl.sv
// tb/tb_vga_fb_fill_ctrl.sv - register vector table plus directed fill, clip, collision, vblank and reset sequences
module tb_vga_fb_fill_ctrl;
  import vga_pkg::*;

  localparam int AW = 19;
  localparam int DW = 24;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic [31:0]   paddr = '0;
  logic          psel = 1'b0;
  logic          penable = 1'b0;
  logic          pwrite = 1'b0;
  logic [31:0]   pwdata = '0;
  logic          pready;
  logic [31:0]   prdata;
  logic          pslverr;
  logic          vblank_start = 1'b0;
  logic          cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          fb_we;
  logic [AW-1:0] fb_addr;
  logic [DW-1:0] fb_wdata;
  logic          irq;

  always #5 clock = ~clock;

  vga_fb_fill_ctrl #(.H_RES(640), .V_RES(480), .AW(AW), .DW(DW)) dut (
    .clock        (clock),
    .reset        (reset),
    .paddr        (paddr),
    .psel         (psel),
    .penable      (penable),
    .pwrite       (pwrite),
    .pwdata       (pwdata),
    .pready       (pready),
    .prdata       (prdata),
    .pslverr      (pslverr),
    .vblank_start (vblank_start),
    .cpu_we       (cpu_we),
    .cpu_addr     (cpu_addr),
    .cpu_wdata    (cpu_wdata),
    .fb_we        (fb_we),
    .fb_addr      (fb_addr),
    .fb_wdata     (fb_wdata),
    .irq          (irq)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            cyc;
  } px_t;

  typedef struct {
    logic        wr;
    logic [2:0]  idx;
    logic [31:0] data;
    logic [31:0] exp;
    logic        exp_err;
  } vec_t;

  px_t  got_q[$];
  px_t  exp_q[$];
  px_t  mon_px;
  vec_t vt[17];
  int   cyc = 0;
  int   irq_rise = -1;
  logic irq_prev = 1'b0;
  int   n_vec = 0;
  int   n_bad = 0;

  always @(posedge clock) cyc <= cyc + 1;

  // Capture every framebuffer write and the first irq rise, late in the low phase
  always @(negedge clock) begin
    #3;
    if (fb_we === 1'b1) begin
      mon_px.addr = fb_addr;
      mon_px.data = fb_wdata;
      mon_px.cyc  = cyc;
      got_q.push_back(mon_px);
    end
    if (irq === 1'b1 && irq_prev == 1'b0 && irq_rise < 0) irq_rise = cyc;
    irq_prev = irq;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic apb(input logic wr, input logic [2:0] idx, input logic [31:0] d,
                     output logic [31:0] rd, output logic err, output int t);
    paddr   = 32'h4000_0000 | (32'(idx) << 2);
    pwrite  = wr;
    pwdata  = d;
    psel    = 1'b1;
    penable = 1'b0;
    @(negedge clock);
    penable = 1'b1;
    #1;
    rd  = prdata;
    err = pslverr;
    t   = cyc;
    @(negedge clock);
    psel    = 1'b0;
    penable = 1'b0;
    pwrite  = 1'b0;
  endtask

  task automatic wr_reg(input logic [2:0] idx, input logic [31:0] d);
    logic [31:0] r;
    logic        e;
    int          t;
    apb(1'b1, idx, d, r, e, t);
  endtask

  task automatic rd_chk(input string name, input logic [2:0] idx, input logic [31:0] exp);
    logic [31:0] r;
    logic        e;
    int          t;
    apb(1'b0, idx, 32'h0, r, e, t);
    check(name, r, exp);
  endtask

  task automatic start_fill(input int x, input int y, input int w, input int h,
                            input logic [DW-1:0] c, input logic [31:0] ctrl, output int t);
    logic [31:0] r;
    logic        e;
    wr_reg(REG_ORIGIN, {6'd0, 10'(y), 6'd0, 10'(x)});
    wr_reg(REG_SIZE, {6'd0, 10'(h), 6'd0, 10'(w)});
    wr_reg(REG_COLOR, {8'd0, c});
    got_q.delete();
    irq_rise = -1;
    apb(1'b1, REG_CTRL, ctrl, r, e, t);
  endtask

  task automatic exp_push(input int a, input logic [DW-1:0] c, input int cy);
    px_t p;
    p.addr = AW'(a);
    p.data = c;
    p.cyc  = cy;
    exp_q.push_back(p);
  endtask

  task automatic exp_rect(input int x, input int y, input int ew, input int eh,
                          input logic [DW-1:0] c, input int t0);
    for (int r = 0; r < eh; r++)
      for (int cc = 0; cc < ew; cc++)
        exp_push((y + r) * 640 + x + cc, c, t0 + r * ew + cc);
  endtask

  task automatic check_log(input string name);
    int n;
    check({name, "_count"}, got_q.size(), exp_q.size());
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_px%0d_addr", name, i), 32'(got_q[i].addr), 32'(exp_q[i].addr));
      check($sformatf("%s_px%0d_data", name, i), 32'(got_q[i].data), 32'(exp_q[i].data));
      check($sformatf("%s_px%0d_cycle", name, i), got_q[i].cyc, exp_q[i].cyc);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [31:0] r;
    logic        e;
    int          t;
    int          v;

    vt[0]  = '{1'b0, REG_CTRL,   32'h0,         32'h0,         1'b0};
    vt[1]  = '{1'b0, REG_STATUS, 32'h0,         32'h0,         1'b0};
    vt[2]  = '{1'b0, REG_ORIGIN, 32'h0,         32'h0,         1'b0};
    vt[3]  = '{1'b0, REG_SIZE,   32'h0,         32'h0,         1'b0};
    vt[4]  = '{1'b0, REG_COLOR,  32'h0,         32'h0,         1'b0};
    vt[5]  = '{1'b1, REG_ORIGIN, 32'hFFFF_FFFF, 32'h0,         1'b0};
    vt[6]  = '{1'b0, REG_ORIGIN, 32'h0,         32'h03FF_03FF, 1'b0};
    vt[7]  = '{1'b1, REG_SIZE,   32'hABCD_1234, 32'h0,         1'b0};
    vt[8]  = '{1'b0, REG_SIZE,   32'h0,         32'h03CD_0234, 1'b0};
    vt[9]  = '{1'b1, REG_COLOR,  32'hFFFF_FFFF, 32'h0,         1'b0};
    vt[10] = '{1'b0, REG_COLOR,  32'h0,         32'h00FF_FFFF, 1'b0};
    vt[11] = '{1'b1, REG_CTRL,   32'h6,         32'h0,         1'b0};
    vt[12] = '{1'b0, REG_CTRL,   32'h0,         32'h6,         1'b0};
    vt[13] = '{1'b0, 3'd5,       32'h0,         32'h0,         1'b1};
    vt[14] = '{1'b1, 3'd6,       32'hDEAD_BEEF, 32'h0,         1'b1};
    vt[15] = '{1'b0, 3'd7,       32'h0,         32'h0,         1'b1};
    vt[16] = '{1'b0, REG_STATUS, 32'h0,         32'h0,         1'b0};

    repeat (3) @(negedge clock);
    check("reset_fb_we", fb_we, 0);
    check("reset_irq", irq, 0);
    check("reset_prdata", prdata, 0);
    check("reset_pslverr", pslverr, 0);
    check("pready", pready, 1);
    reset = 1'b0;

    for (int i = 0; i < 17; i++) begin
      apb(vt[i].wr, vt[i].idx, vt[i].data, r, e, t);
      if (!vt[i].wr) check($sformatf("vec%0d_prdata", i), r, vt[i].exp);
      check($sformatf("vec%0d_pslverr", i), e, vt[i].exp_err);
    end

    start_fill(10, 5, 4, 2, 24'hFF0000, 32'h5, t);
    repeat (12) @(negedge clock);
    exp_q.delete();
    exp_rect(10, 5, 4, 2, 24'hFF0000, t + 1);
    check_log("basic");
    check("basic_irq_cycle", irq_rise, t + 10);
    rd_chk("basic_status", REG_STATUS, 32'h2);
    wr_reg(REG_CTRL, 32'h0);
    check("basic_irq_masked", irq, 0);
    wr_reg(REG_CTRL, 32'h4);
    check("basic_irq_unmasked", irq, 1);
    wr_reg(REG_STATUS, 32'h2);
    check("basic_irq_cleared", irq, 0);
    rd_chk("basic_status_clr", REG_STATUS, 32'h0);

    start_fill(638, 479, 8, 4, 24'h00AA55, 32'h5, t);
    repeat (8) @(negedge clock);
    exp_q.delete();
    exp_push(307198, 24'h00AA55, t + 1);
    exp_push(307199, 24'h00AA55, t + 2);
    check_log("clip");
    check("clip_irq_cycle", irq_rise, t + 4);
    rd_chk("clip_status", REG_STATUS, 32'h2);
    wr_reg(REG_STATUS, 32'h2);

    start_fill(5, 5, 0, 3, 24'h111111, 32'h1, t);
    repeat (4) @(negedge clock);
    exp_q.delete();
    check_log("inv_w0");
    rd_chk("inv_w0_status", REG_STATUS, 32'h6);
    wr_reg(REG_STATUS, 32'h6);
    rd_chk("inv_w0_status_clr", REG_STATUS, 32'h0);

    start_fill(640, 0, 2, 2, 24'h222222, 32'h1, t);
    repeat (4) @(negedge clock);
    check_log("inv_x640");
    rd_chk("inv_x640_status", REG_STATUS, 32'h6);
    wr_reg(REG_STATUS, 32'h6);
    rd_chk("inv_x640_status_clr", REG_STATUS, 32'h0);

    start_fill(20, 1, 4, 1, 24'h0000FF, 32'h5, t);
    @(negedge clock);
    cpu_we    = 1'b1;
    cpu_addr  = 19'd5;
    cpu_wdata = 24'h00FF00;
    repeat (2) @(negedge clock);
    cpu_we = 1'b0;
    repeat (8) @(negedge clock);
    exp_q.delete();
    exp_push(660, 24'h0000FF, t + 1);
    exp_push(5, 24'h00FF00, t + 2);
    exp_push(5, 24'h00FF00, t + 3);
    exp_push(661, 24'h0000FF, t + 4);
    exp_push(662, 24'h0000FF, t + 5);
    exp_push(663, 24'h0000FF, t + 6);
    check_log("coll");
    check("coll_irq_cycle", irq_rise, t + 8);
    rd_chk("coll_status", REG_STATUS, 32'h2);
    wr_reg(REG_STATUS, 32'h2);

    start_fill(0, 2, 2, 1, 24'h0080FF, 32'h7, t);
    repeat (3) @(negedge clock);
    wr_reg(REG_COLOR, 32'h0012_3456);
    wr_reg(REG_CTRL, 32'h7);
    rd_chk("vb_status_busy", REG_STATUS, 32'h5);
    check("vb_no_write_before_vblank", got_q.size(), 0);
    vblank_start = 1'b1;
    v = cyc;
    @(negedge clock);
    vblank_start = 1'b0;
    repeat (6) @(negedge clock);
    exp_q.delete();
    exp_push(1280, 24'h0080FF, v + 1);
    exp_push(1281, 24'h0080FF, v + 2);
    check_log("vb");
    check("vb_irq_cycle", irq_rise, v + 4);
    rd_chk("vb_status", REG_STATUS, 32'h6);
    rd_chk("vb_color_kept", REG_COLOR, 32'h0000_80FF);
    wr_reg(REG_STATUS, 32'h6);

    start_fill(0, 10, 4, 4, 24'hABCDEF, 32'h5, t);
    for (int i = 0; i < 20 && got_q.size() < 3; i++) @(negedge clock);
    check("rst_reached_px3", got_q.size(), 3);
    reset     = 1'b1;
    cpu_we    = 1'b1;
    cpu_addr  = 19'd77;
    cpu_wdata = 24'h111111;
    @(negedge clock);
    reset  = 1'b0;
    cpu_we = 1'b0;
    repeat (5) @(negedge clock);
    exp_q.delete();
    exp_rect(0, 10, 3, 1, 24'hABCDEF, t + 1);
    exp_push(77, 24'h111111, t + 4);
    check_log("rst");
    check("rst_irq", irq, 0);
    rd_chk("rst_ctrl", REG_CTRL, 32'h0);
    rd_chk("rst_status", REG_STATUS, 32'h0);
    rd_chk("rst_origin", REG_ORIGIN, 32'h0);
    rd_chk("rst_size", REG_SIZE, 32'h0);
    rd_chk("rst_color", REG_COLOR, 32'h0);

    start_fill(3, 0, 2, 1, 24'h00FF00, 32'h1, t);
    repeat (6) @(negedge clock);
    exp_q.delete();
    exp_rect(3, 0, 2, 1, 24'h00FF00, t + 1);
    check_log("post_rst");
    rd_chk("post_rst_status", REG_STATUS, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_fb_fill_ctrl.md
Name: vga_fb_fill_ctrl

Overview:
- Hardware rectangle-fill engine for the 640x480, 24-bit VGA framebuffer (one pixel per word, word index = y*640 + x).
- Sits between the CPU's APB framebuffer write path and the framebuffer's single write port. Arbitrates that port, with the CPU always winning.
- Configured through its own small APB register slave. Raises a done interrupt.

Parameters:
- H_RES, 640, active pixels per line
- V_RES, 480, active lines per frame
- AW, 19, framebuffer word-address width
- DW, 24, pixel width (RGB888)

Ports:
- clock  in  1  system clock
- reset  in  1  synchronous, active-high
- paddr  in  32  APB address; only [4:2] decoded
- psel  in  1  APB select
- penable  in  1  APB enable
- pwrite  in  1  APB write
- pwdata  in  32  APB write data
- pready  out  1  constant 1
- prdata  out  32  APB read data
- pslverr  out  1  error response
- vblank_start  in  1  one-cycle pulse at the start of vertical blanking
- cpu_we  in  1  CPU framebuffer write strobe
- cpu_addr  in  AW  CPU pixel index
- cpu_wdata  in  DW  CPU pixel data
- fb_we  out  1  framebuffer write enable
- fb_addr  out  AW  framebuffer write index
- fb_wdata  out  DW  framebuffer write data
- irq  out  1  done interrupt, level

Behaviour:
- Reset values: all registers 0, state IDLE, fb_we=0, irq=0, prdata=0, pslverr=0.
- APB access: an access occurs on psel&penable, with zero wait states.
- Register map (index = paddr[4:2]):
  - 0 CTRL: bit0 START (write-1 pulse, reads 0), bit1 WAIT_VB, bit2 IRQ_EN.
  - 1 STATUS: bit0 BUSY (read-only), bit1 DONE (sticky, write-1-clear), bit2 ERR (sticky, write-1-clear).
  - 2 ORIGIN: x[9:0], y[25:16].
  - 3 SIZE: w[9:0], h[25:16].
  - 4 COLOR: [23:0].
- Index 5..7: pslverr=1 during the access; writes ignored; prdata=0.
- prdata is combinational during read accesses and 0 otherwise. Unused bits read 0.
- Writes to ORIGIN, SIZE or COLOR while BUSY are ignored and set ERR.
- START while BUSY is ignored and sets ERR.
- State machine: IDLE, WAIT_VB, FILL, DONE.
  - IDLE -> validate on the START write.
  - Invalid if w==0, h==0, x>=H_RES or y>=V_RES. Invalid -> DONE with ERR set; no pixel is written.
  - Valid, WAIT_VB=1 -> WAIT_VB. Valid, WAIT_VB=0 -> FILL.
  - WAIT_VB -> FILL on the first vblank_start strictly after entry.
  - FILL -> DONE after the last pixel write is granted.
  - DONE (one cycle) -> IDLE, setting DONE.
  - BUSY = state != IDLE.
- Clipping, computed at START:
  - ew = min(w, H_RES-x)
  - eh = min(h, V_RES-y)
- Addressing:
  - row_base starts at y*H_RES, built by shift-add (640 = 512+128); no general multiplier.
  - Column counter cx runs 0..ew-1. Pixel address = row_base + x + cx.
  - At row end: cx <= 0, row_base += H_RES, row counter increments. The final pixel is at row eh-1, col ew-1.
- Arbitration (combinational mux):
  - cpu_we=1: fb_* = cpu_*; the engine stalls and holds cx, row and address.
  - Otherwise, in FILL: fb_we=1, fb_addr = engine address, fb_wdata = COLOR.
  - The engine writes exactly one pixel per granted cycle.
- Latency: START accepted in cycle T with WAIT_VB=0 -> first engine write in cycle T+1. An unstalled fill takes ew*eh FILL cycles; DONE is set at the end of cycle T+ew*eh+1.
- irq = STATUS.DONE & CTRL.IRQ_EN. Clearing DONE drops irq the next cycle.
- DONE/ERR clear written in the same cycle as a hardware set: the set wins.
- Reset mid-fill aborts immediately with no further fb_we from the engine. The CPU path passes through unconditionally, including during reset.

Decomposition:
- Package vga_pkg:
  - H_RES/V_RES constants and register index constants (CTRL..COLOR).
  - CTRL/STATUS bit positions.
  - State enum {IDLE, WAIT_VB, FILL, DONE}.
- One sub-module, vga_fill_regs: APB decode, register file, sticky bits, pslverr.
- The FSM, address generator and arbiter mux stay in the top.

Test Plan:
- Basic fill: ORIGIN x=10 y=5, SIZE w=4 h=2, COLOR 0xFF0000, START -> 8 consecutive fb_we with addresses 3210..3213, 3850..3853 and data 0xFF0000; DONE=1 on the next cycle; irq follows IRQ_EN.
- Clipping: x=638 y=479 w=8 h=4 -> exactly 2 writes (307198, 307199); ERR=0; DONE=1.
- Invalid: w=0, or x=640 -> no fb_we; STATUS reads 0b110; a write of 0b110 to STATUS clears it to 0.
- CPU collision: cpu_we held for cycles 2-3 of a 4x1 fill (cpu_addr=5, data 0x00FF00) -> fb shows the CPU writes in those cycles; engine addresses are contiguous with no skip or duplicate; the fill completes 2 cycles late.
- Vblank wait: WAIT_VB=1, START -> no fb_we until the cycle after the vblank_start pulse; START again while BUSY -> ERR=1 and the fill is unaffected.
- Reset mid-fill at pixel 3 of 4x4 -> fb_we=0 in the next cycle; all registers read 0; a new START works normally.
